// File: rtl/program_counter_if.sv
// rtl/program_counter_if.sv - fetch-address bus between the core control logic and the program counter
interface program_counter_if;
    logic        stall;
    logic        branch_taken;
    logic [11:0] branch_offset;
    logic        jal_en;
    logic [20:1] jal_offset;
    logic        jalr_en;
    logic [31:0] jalr_target;
    logic [31:0] inst_add;
    logic        inst_valid;
    logic [31:0] pc_plus4;
    logic        fault;

    modport master (
        output stall, branch_taken, branch_offset, jal_en, jal_offset, jalr_en, jalr_target,
        input  inst_add, inst_valid, pc_plus4, fault
    );

    modport slave (
        input  stall, branch_taken, branch_offset, jal_en, jal_offset, jalr_en, jalr_target,
        output inst_add, inst_valid, pc_plus4, fault
    );
endinterface

// File: rtl/program_counter.sv
// rtl/program_counter.sv - fetch address generator with sequential wrap, redirects and sticky fault
// Optional macro PC_BOUND_CHECK_EN also rejects redirect targets outside [RESET_PC, PC_MAX].
module program_counter #(
    parameter int RESET_PC = 40,
    parameter int PC_MAX   = 144
) (
    input  logic              clk,
    input  logic              reset,
    program_counter_if.slave  bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] BUBBLE = 2'd2;
    localparam logic [1:0] FAULT  = 2'd3;

    localparam logic [31:0] RESET_PC_W = 32'(RESET_PC);
    localparam logic [31:0] PC_MAX_W   = 32'(PC_MAX);

    logic [1:0]  r_state;
    logic [31:0] r_inst_add;
    logic        r_inst_valid;
    logic        r_fault;

    logic [31:0] w_branch_tgt;
    logic [31:0] w_jal_tgt;
    logic [31:0] w_jalr_tgt;
    logic [31:0] w_target;
    logic        w_redirect;
    logic        w_illegal;
    logic [31:0] w_seq_next;

    assign w_branch_tgt = r_inst_add + {{20{bus.branch_offset[11]}}, bus.branch_offset};
    assign w_jal_tgt    = r_inst_add + {{11{bus.jal_offset[20]}}, bus.jal_offset, 1'b0};
    assign w_jalr_tgt   = bus.jalr_target & ~32'd1;
    assign w_seq_next   = (r_inst_add == PC_MAX_W) ? RESET_PC_W : r_inst_add + 32'd4;

    always_comb begin
        w_redirect = 1'b0;
        w_target   = w_branch_tgt;
        if (bus.jalr_en) begin
            w_redirect = 1'b1;
            w_target   = w_jalr_tgt;
        end else if (bus.jal_en) begin
            w_redirect = 1'b1;
            w_target   = w_jal_tgt;
        end else if (bus.branch_taken) begin
            w_redirect = 1'b1;
            w_target   = w_branch_tgt;
        end
    end

`ifdef PC_BOUND_CHECK_EN
    assign w_illegal = (w_target[1:0] != 2'b00) || (w_target < RESET_PC_W) || (w_target > PC_MAX_W);
`else
    assign w_illegal = (w_target[1:0] != 2'b00);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_inst_add   <= RESET_PC_W;
            r_inst_valid <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state      <= RUN;
                    r_inst_valid <= 1'b1;
                end
                RUN: begin
                    if (w_redirect) begin
                        r_inst_valid <= 1'b0;
                        // Illegal targets leave the address at the instruction that redirected.
                        if (w_illegal) begin
                            r_state <= FAULT;
                            r_fault <= 1'b1;
                        end else begin
                            r_state    <= BUBBLE;
                            r_inst_add <= w_target;
                        end
                    end else if (!bus.stall) begin
                        r_inst_add <= w_seq_next;
                    end
                end
                BUBBLE: begin
                    r_state      <= RUN;
                    r_inst_valid <= 1'b1;
                end
                default: begin
                    r_state <= FAULT;
                end
            endcase
        end
    end

    assign bus.inst_add   = r_inst_add;
    assign bus.inst_valid = r_inst_valid;
    assign bus.pc_plus4   = r_inst_add + 32'd4;
    assign bus.fault      = r_fault;
endmodule
